// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   N-channel ESC pulse generator with an arming sequence and a receiver-loss
//   failsafe. A free-running frame counter defines the PWM frame. Every motor
//   has a shadow pulse width (captured from motor_rates on rate_valid) and an
//   active pulse width (copied from the shadow at the last tick of a frame).
//   Pulse widths therefore only change on frame boundaries.
//
// Ports
//   sys_clk      system clock
//   reset        asynchronous, active-high reset
//   motor_rates  packed per-motor rates, motor i at [i*RATE_BIT_WIDTH +: RATE_BIT_WIDTH]
//   rate_valid   one-cycle strobe qualifying motor_rates
//   arm          level arm request from the receiver aux switch
//   motor_pwm    registered ESC pulse outputs
//   armed        high while the driver is in ARMED
//   failsafe     high while the driver is in FAILSAFE
//   frame_start  one-cycle pulse coincident with the pulse rising edges
module motor_pwm_driver #(
  parameter int NUM_MOTORS      = 4,
  parameter int RATE_BIT_WIDTH  = 18,
  parameter int PERIOD_TICKS    = 332500,
  parameter int MIN_PULSE_TICKS = 133000,
  parameter int MAX_PULSE_TICKS = 266000,
  parameter int ARM_PERIODS     = 400,
  parameter int TIMEOUT_PERIODS = 40
) (
  input  logic                                 sys_clk,
  input  logic                                 reset,
  input  logic [NUM_MOTORS*RATE_BIT_WIDTH-1:0] motor_rates,
  input  logic                                 rate_valid,
  input  logic                                 arm,
  output logic [NUM_MOTORS-1:0]                motor_pwm,
  output logic                                 armed,
  output logic                                 failsafe,
  output logic                                 frame_start
);

  // Pulse widths never exceed MAX_PULSE_TICKS < PERIOD_TICKS, so they share
  // the frame counter width.
  localparam int CNT_W  = $clog2(PERIOD_TICKS);
  localparam int ARM_W  = $clog2(ARM_PERIODS + 1);
  localparam int TO_W   = $clog2(TIMEOUT_PERIODS + 1);
  localparam int SPAN   = MAX_PULSE_TICKS - MIN_PULSE_TICKS;
  localparam int CMP_W  = (RATE_BIT_WIDTH > CNT_W) ? RATE_BIT_WIDTH : CNT_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PULSE_TICKS);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PERIODS - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_PERIODS);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  // Clamp the rate to the allowed span before adding the minimum so the sum
  // can never overflow the pulse width register.
  function automatic logic [CNT_W-1:0] shadow_value(input logic [RATE_BIT_WIDTH-1:0] rate);
    logic [CMP_W-1:0] rate_ext;
    logic [CMP_W-1:0] span_ext;
    logic [CMP_W-1:0] sel;
    rate_ext = CMP_W'(rate);
    span_ext = CMP_W'(SPAN);
    sel      = (rate_ext > span_ext) ? span_ext : rate_ext;
    return CNT_W'(sel) + MIN_P;
  endfunction

  logic [CNT_W-1:0]          cnt_r;
  logic                      wrap_s;
  logic                      go_armed_s;
  state_t                    state_r;
  logic [ARM_W-1:0]          arm_cnt_r;
  logic [TO_W-1:0]           timeout_r;
  logic [TO_W-1:0]           timeout_nxt_s;
  logic [RATE_BIT_WIDTH-1:0] rates_s  [NUM_MOTORS];
  logic [CNT_W-1:0]          shadow_r [NUM_MOTORS];
  logic [CNT_W-1:0]          active_r [NUM_MOTORS];
  logic [NUM_MOTORS-1:0]     pwm_r;
  logic                      frame_start_r;
  logic                      armed_r;
  logic                      failsafe_r;

  // Unpack the per-motor rate fields.
  always_comb begin
    for (int i = 0; i < NUM_MOTORS; i++) begin
      rates_s[i] = motor_rates[i*RATE_BIT_WIDTH +: RATE_BIT_WIDTH];
    end
  end

  // Frame-boundary and arming-complete decodes.
  always_comb begin
    wrap_s     = (cnt_r == CNT_LAST);
    go_armed_s = (state_r == ST_ARMING) && arm && wrap_s && (arm_cnt_r == ARM_LAST);
  end

  // Next receiver-loss count: cleared by a fresh rate, counts frames, saturates.
  always_comb begin
    if (rate_valid) begin
      timeout_nxt_s = '0;
    end else if (wrap_s && (timeout_r != TO_LIMIT)) begin
      timeout_nxt_s = timeout_r + TO_W'(1);
    end else begin
      timeout_nxt_s = timeout_r;
    end
  end

  // Free-running frame counter.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (wrap_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Shadow widths: captured on rate_valid, forced to idle when arming completes
  // so stale pre-arm rates never reach the motors.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        shadow_r[i] <= MIN_P;
      end
    end else if (go_armed_s) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        shadow_r[i] <= MIN_P;
      end
    end else if (rate_valid) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        shadow_r[i] <= shadow_value(rates_s[i]);
      end
    end
  end

  // Active widths: loaded on the last tick of each frame; only ARMED passes
  // the commanded width through, every other state idles the motors.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        active_r[i] <= MIN_P;
      end
    end else if (wrap_s) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        active_r[i] <= (state_r == ST_ARMED) ? shadow_r[i] : MIN_P;
      end
    end
  end

  // Registered pulse outputs and frame marker; both derive from the same
  // counter value so frame_start lines up with the rising edges.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pwm_r         <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= (cnt_r == '0);
      for (int i = 0; i < NUM_MOTORS; i++) begin
        pwm_r[i] <= (cnt_r < active_r[i]);
      end
    end
  end

  // Arming / failsafe state machine with registered status outputs. Every
  // transition clears the receiver-loss count; arm=0 always wins.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_DISARMED;
      arm_cnt_r  <= '0;
      timeout_r  <= '0;
      armed_r    <= 1'b0;
      failsafe_r <= 1'b0;
    end else begin
      timeout_r <= timeout_nxt_s;
      case (state_r)
        ST_DISARMED: begin
          if (arm) begin
            state_r   <= ST_ARMING;
            arm_cnt_r <= '0;
            timeout_r <= '0;
          end
        end
        ST_ARMING: begin
          if (!arm) begin
            state_r   <= ST_DISARMED;
            timeout_r <= '0;
          end else if (go_armed_s) begin
            state_r   <= ST_ARMED;
            armed_r   <= 1'b1;
            timeout_r <= '0;
          end else if (wrap_s) begin
            arm_cnt_r <= arm_cnt_r + ARM_W'(1);
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state_r   <= ST_DISARMED;
            armed_r   <= 1'b0;
            timeout_r <= '0;
          end else if (timeout_r == TO_LIMIT) begin
            state_r    <= ST_FAILSAFE;
            armed_r    <= 1'b0;
            failsafe_r <= 1'b1;
            timeout_r  <= '0;
          end
        end
        ST_FAILSAFE: begin
          // Resumed rates do not recover; only disarming leaves failsafe.
          if (!arm) begin
            state_r    <= ST_DISARMED;
            failsafe_r <= 1'b0;
            timeout_r  <= '0;
          end
        end
        default: begin
          state_r    <= ST_DISARMED;
          armed_r    <= 1'b0;
          failsafe_r <= 1'b0;
          timeout_r  <= '0;
        end
      endcase
    end
  end

  assign motor_pwm   = pwm_r;
  assign frame_start = frame_start_r;
  assign armed       = armed_r;
  assign failsafe    = failsafe_r;

endmodule
